disp_frame_seq: RTL

- Parametrised frame sequencer for the display pipeline; successor to the fixed Swap/Background/Test controller.
- Each frame, it runs up to NS draw-engine stages in ascending index order via start/done pulse handshakes, then requests a buffer swap.
- Adds a per-frame stage enable mask, continuous or single-shot operation, a per-stage watchdog and a frame counter.
- Sits between the display top level and its draw engines and swap engine on clkSYS.

---
 rtl/disp_frame_seq.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/disp_frame_seq.sv
// Frame sequencer for the display pipeline: runs enabled draw stages in index order,
// then requests a buffer swap. Includes a per-stage watchdog and a completed-frame counter.
module disp_frame_seq #(
  parameter int NS = 4,
  parameter int TW = 16,
  parameter int FW = 16
) (
  input  logic          clkSYS,
  input  logic          n_reset,
  input  logic          run,
  input  logic          trigger,
  input  logic [NS-1:0] en_mask,
  input  logic [TW-1:0] tmo,
  output logic [NS-1:0] start,
  input  logic [NS-1:0] done,
  output logic          swap_start,
  input  logic          swap_done,
  output logic          busy,
  output logic [FW-1:0] frame_cnt,
  output logic          err,
  output logic [4:0]    err_stage,
  input  logic          clr_err
);
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [4:0] SWAP_ID = 5'd16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_SWAPL  = 3'd3,
    S_SWAPW  = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic [SW-1:0] stage_reg, stage_next;
  logic [NS-1:0] mask_reg, mask_next;
  logic [TW-1:0] wd_reg, wd_next;
  logic [FW-1:0] frame_reg;
  logic          frame_inc;
  logic          err_reg;
  logic [4:0]    err_stage_reg;
  logic [NS-1:0] start_reg, start_next;
  logic          swap_reg, swap_next;

  logic [NS-1:0] above_mask;
  logic          first_hit, above_hit;
  logic [SW-1:0] first_idx, above_idx;

  logic in_wait, in_swapw, got_done, wd_on, wd_expire, advance;

  // Enabled stages strictly above the current one; disabled stages are skipped in zero cycles.
  genvar gi;
  generate
    for (gi = 0; gi < NS; gi = gi + 1) begin : g_above
      assign above_mask[gi] = mask_reg[gi] && (SW'(gi) > stage_reg);
    end
  endgenerate

  always_comb begin
    first_hit = 1'b0;
    first_idx = '0;
    above_hit = 1'b0;
    above_idx = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (en_mask[i]) begin
        first_hit = 1'b1;
        first_idx = SW'(i);
      end
      if (above_mask[i]) begin
        above_hit = 1'b1;
        above_idx = SW'(i);
      end
    end
  end

  assign in_wait   = (state_reg == S_WAIT);
  assign in_swapw  = (state_reg == S_SWAPW);
  assign got_done  = (in_wait && done[stage_reg]) || (in_swapw && swap_done);
  assign wd_on     = (in_wait || in_swapw) && (tmo != '0);
  // A done in the expiry cycle wins, so the stage completes without an error.
  assign wd_expire = wd_on && (wd_reg == (tmo - TW'(1))) && !got_done;
  assign advance   = got_done || wd_expire;

  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) begin
      state_reg     <= S_IDLE;
      stage_reg     <= '0;
      mask_reg      <= '0;
      wd_reg        <= '0;
      frame_reg     <= '0;
      err_reg       <= 1'b0;
      err_stage_reg <= '0;
      start_reg     <= '0;
      swap_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      stage_reg <= stage_next;
      mask_reg  <= mask_next;
      wd_reg    <= wd_next;
      start_reg <= start_next;
      swap_reg  <= swap_next;
      if (frame_inc) begin
        frame_reg <= frame_reg + FW'(1);
      end
      if (clr_err) begin
        err_reg       <= 1'b0;
        err_stage_reg <= '0;
      end else if (wd_expire) begin
        err_reg <= 1'b1;
        if (!err_reg) begin
          err_stage_reg <= in_swapw ? SWAP_ID : 5'(stage_reg);
        end
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    stage_next = stage_reg;
    mask_next  = mask_reg;
    frame_inc  = 1'b0;
    wd_next    = wd_reg;

    if ((state_reg == S_LAUNCH) || (state_reg == S_SWAPL)) begin
      wd_next = '0;
    end else if (wd_on && (wd_reg != '1)) begin
      wd_next = wd_reg + TW'(1);
    end

    case (state_reg)
      S_IDLE: begin
        if (run || trigger) begin
          mask_next = en_mask;
          if (first_hit) begin
            state_next = S_LAUNCH;
            stage_next = first_idx;
          end else begin
            state_next = S_SWAPL;
          end
        end
      end
      S_LAUNCH: state_next = S_WAIT;
      S_WAIT: begin
        if (advance) begin
          if (above_hit) begin
            state_next = S_LAUNCH;
            stage_next = above_idx;
          end else begin
            state_next = S_SWAPL;
          end
        end
      end
      S_SWAPL: state_next = S_SWAPW;
      S_SWAPW: begin
        if (advance) begin
          frame_inc = 1'b1;
          // Continuous mode chains straight into the next frame with no idle gap.
          if (run) begin
            mask_next = en_mask;
            if (first_hit) begin
              state_next = S_LAUNCH;
              stage_next = first_idx;
            end else begin
              state_next = S_SWAPL;
            end
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    start_next = '0;
    if (state_next == S_LAUNCH) begin
      start_next[stage_next] = 1'b1;
    end
    swap_next = (state_next == S_SWAPL);
  end

  assign start      = start_reg;
  assign swap_start = swap_reg;
  assign busy       = (state_reg != S_IDLE);
  assign frame_cnt  = frame_reg;
  assign err        = err_reg;
  assign err_stage  = err_stage_reg;

endmodule
